axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- Memory-side responder for the core's memory-control handshake: the other end of the initiator that drives AXIStart, DRW, addressM and writeDataM and waits for doneM.
- Accepts one word transaction per AXIStart rising edge and waits a programmable latency to model DDR3.
- Performs the read or write on an internal word RAM, then pulses doneM, with readDataM valid for reads.
- Stands in for the DDR3/AXI path in simulation and on-board bring-up.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed 32 in this revision.
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).
- LATENCY, 4, wait cycles between accept and access; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- AXIStart  in  1  transaction request; only its rising edge is significant.
- DRW  in  1  direction, sampled at accept; 1 = write, 0 = read.
- addressM  in  ADDR_W  byte address, sampled at accept.
- writeDataM  in  DATA_W  write data, sampled at accept.
- doneM  out  1  one-cycle completion pulse.
- readDataM  out  DATA_W  read result; held until the next read completes.
- busy  out  1  high from the accept cycle through the DONE cycle inclusive.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; doneM=0, busy=0, readDataM=0.
  - Latency counter=0; start-edge register=0.
  - RAM contents are not cleared.
  - Reset mid-transaction aborts it; a pending write is not performed.
- Edge detect: start_q <= AXIStart each cycle; accept = AXIStart & ~start_q & (state==IDLE).
  - A start held high across completion does not retrigger.
  - A rising edge seen outside IDLE is dropped, with no queueing.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE: on accept, latch DRW, word index = addressM[DEPTH_LOG2+1:2], and writeDataM; counter <= LATENCY-1; go to WAIT.
  - WAIT: decrement counter; when counter==0, go to ACCESS. WAIT therefore lasts LATENCY cycles.
  - ACCESS: write → RAM[idx] <= wdata. Read → issue synchronous RAM read. Go to DONE.
  - DONE: doneM=1 for exactly this cycle. On a read, readDataM is updated to the RAM output in this same cycle. Go to IDLE.
- Latency: the accept edge is cycle 0 and doneM rises at cycle LATENCY+2. Minimum accept-to-accept spacing is LATENCY+3 cycles.
- Addressing:
  - addressM[1:0] is ignored; accesses are whole words only.
  - Upper bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo DEPTH words.
- Read-after-write to the same word in back-to-back transactions returns the new data.
- The DRW, address and data inputs may change freely after accept without effect.

Optional Feature:
- Macro: AXI_MEM_RESPONDER_OOR_ERR_EN.
- When defined:
  - Add output port errM (1 bit). It is valid with doneM and is 1 when any address bit above DEPTH_LOG2+1 is nonzero at accept.
  - Out-of-range writes are suppressed.
  - Out-of-range reads return 32'hDEADBEEF.
  - errM is 0 at reset and outside the DONE cycle.
- When undefined: no errM port, and all addresses wrap as above.

Decomposition:
- Package axi_mem_resp_pkg:
  - State enum (IDLE, WAIT, ACCESS, DONE).
  - DRW encodings DRW_READ=0 and DRW_WRITE=1.
  - OOR_READ_DATA=32'hDEADBEEF.
- Sub-module axi_mem_resp_ram:
  - Single-port synchronous RAM with parameters DEPTH_LOG2 and DATA_W.
  - Ports: clk, we, addr, wdata, rdata; rdata registered, 1-cycle read.
  - Infers BRAM.
- The FSM, edge detect and counter stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → doneM=0, busy=0, readDataM=0; no doneM for 20 idle cycles.
- Write then read, LATENCY=4:
  - Write 32'hCAFEF00D to 0x0000_0010 → doneM pulses exactly at cycle 6 after the edge.
  - Then read 0x10 → readDataM=32'hCAFEF00D when doneM=1, held afterwards.
- Held start: keep AXIStart=1 for 30 cycles after one read → exactly one doneM pulse. Dropping to 0 and raising again starts a second transaction.
- Busy drop: raise AXIStart during WAIT of a write to 0x20 → the edge is ignored; a single doneM; busy stays high for LATENCY+3 cycles.
- Wrap (macro off):
  - Write 32'h12345678 to 0x0000_1004 with DEPTH_LOG2=10 → a read of 0x4 returns 32'h12345678.
  - Macro on → errM=1 with doneM, and a read of 0x1004 returns 32'hDEADBEEF.
- Reset mid-op: assert reset=0 in WAIT of a write of 32'hFFFFFFFF to 0x8 → no doneM; a later read of 0x8 returns its prior value.

Source files
------------

// File: rtl/axi_mem_resp_pkg.sv
// Shared types and constants for the axi_mem_responder memory model.
package axi_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic        DRW_READ      = 1'b0;
    localparam logic        DRW_WRITE     = 1'b1;
    localparam logic [31:0] OOR_READ_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/axi_mem_resp_ram.sv
// Single-port word RAM with a registered, one-cycle read; written to infer block RAM.
module axi_mem_resp_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// Memory-side responder: one word access per AXIStart rising edge after LATENCY wait cycles.
// Optional AXI_MEM_RESPONDER_OOR_ERR_EN adds errM and blocks accesses beyond the RAM depth.
module axi_mem_responder
    import axi_mem_resp_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AXIStart,
    input  logic              DRW,
    input  logic [ADDR_W-1:0] addressM,
    input  logic [DATA_W-1:0] writeDataM,
    output logic              doneM,
    output logic [DATA_W-1:0] readDataM,
    output logic              busy
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
    ,
    output logic              errM
`endif
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_e                  r_state, w_next;
    logic                    r_start_q;
    logic [7:0]              r_cnt;
    logic                    r_drw;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata;
    logic                    w_accept;
    logic                    w_we;
    logic                    w_rd_now;
    logic [DATA_W-1:0]       w_ram_rdata;
    logic [DATA_W-1:0]       w_rd_val;

    assign w_accept = reset & AXIStart & ~r_start_q & (r_state == IDLE);

`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
    logic r_oor;
    logic w_oor_in;
    logic w_unused_addr;
    assign w_oor_in      = |addressM[ADDR_W-1:DEPTH_LOG2+2];
    assign w_unused_addr = ^addressM[1:0];
    assign w_we          = reset & (r_state == ACCESS) & (r_drw == DRW_WRITE) & ~r_oor;
    assign w_rd_val      = r_oor ? OOR_READ_DATA : w_ram_rdata;
    assign errM          = (r_state == DONE) & r_oor;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{addressM[ADDR_W-1:DEPTH_LOG2+2], addressM[1:0]};
    assign w_we          = reset & (r_state == ACCESS) & (r_drw == DRW_WRITE);
    assign w_rd_val      = w_ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
            r_cnt     <= 8'd0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_next;
            r_start_q <= AXIStart;
            if (w_accept) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == WAIT && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_rd_now) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    // Transaction fields are captured only at accept so later input changes are harmless.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_drw   <= DRW;
            r_idx   <= addressM[DEPTH_LOG2+1:2];
            r_wdata <= writeDataM;
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
            r_oor   <= w_oor_in;
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = WAIT;
            WAIT:    if (r_cnt == 8'd0) w_next = ACCESS;
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read data bypasses the hold register during DONE so it is valid alongside doneM.
    assign w_rd_now  = (r_state == DONE) && (r_drw == DRW_READ);
    assign readDataM = w_rd_now ? w_rd_val : r_rdata;
    assign doneM     = (r_state == DONE);
    assign busy      = (r_state != IDLE) | w_accept;

    axi_mem_resp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .addr  (r_idx),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder; expectations are queued at issue and popped at doneM.
module tb_axi_mem_responder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        AXIStart = 1'b0;
    logic        DRW = 1'b0;
    logic [31:0] addressM = '0;
    logic [31:0] writeDataM = '0;
    logic        doneM;
    logic [31:0] readDataM;
    logic        busy;
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
    logic        errM;
`endif

    axi_mem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .AXIStart   (AXIStart),
        .DRW        (DRW),
        .addressM   (addressM),
        .writeDataM (writeDataM),
        .doneM      (doneM),
        .readDataM  (readDataM),
        .busy       (busy)
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
        ,
        .errM       (errM)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   done_cnt = 0;

    always @(posedge clk) if (doneM === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction; dcyc is the doneM cycle counting the accept cycle as 0.
    task automatic run_txn(input logic drw, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit hold, input bit poke,
                           output int dcyc, output int bcyc,
                           output logic [31:0] rd, output logic er);
        dcyc = -1; bcyc = 0; rd = '0; er = 1'b0;
        AXIStart = 1'b1; DRW = drw; addressM = addr; writeDataM = wdata;
        #1;
        if (busy === 1'b1) bcyc++;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (busy === 1'b1) bcyc++;
            if (doneM === 1'b1 && dcyc < 0) begin
                dcyc = n + 1;
                rd   = readDataM;
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
                er   = errM;
`endif
            end
            if (n == 0) begin
                if (!hold) AXIStart = 1'b0;
                DRW = ~drw; addressM = $urandom; writeDataM = $urandom;
            end
            if (poke && n == 2) AXIStart = 1'b1;
            if (dcyc >= 0 && busy !== 1'b1) break;
        end
        if (!hold) begin
            AXIStart = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        int d0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_total++; if (doneM !== 1'b0) $display("FAIL reset_doneM got %b want 0", doneM); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (readDataM !== 32'h0) $display("FAIL reset_rdata got %h want 0", readDataM); else n_pass++;
        d0 = done_cnt;
        repeat (20) tick();
        n_total++; if (done_cnt !== d0) $display("FAIL reset_idle_done got %0d want %0d", done_cnt, d0); else n_pass++;
    endtask

    task automatic test_write_read();
        int dc, bc; logic [31:0] rd; logic er; exp_t e;
        sb.push_back('{32'h0, 1'b0});
        run_txn(1'b1, 32'h10, 32'hCAFEF00D, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (dc !== L + 2) $display("FAIL wr_done_cycle got %0d want %0d", dc, L + 2); else n_pass++;
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
        n_total++; if (er !== e.err) $display("FAIL wr_err got %b want %b", er, e.err); else n_pass++;
`endif
        n_total++; if (doneM !== 1'b0) $display("FAIL wr_pulse_width got %b want 0", doneM); else n_pass++;
        sb.push_back('{32'hCAFEF00D, 1'b0});
        run_txn(1'b0, 32'h10, 32'h0, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (dc !== L + 2) $display("FAIL rd_done_cycle got %0d want %0d", dc, L + 2); else n_pass++;
        n_total++; if (rd !== e.data) $display("FAIL rd_data got %h want %h", rd, e.data); else n_pass++;
        repeat (5) tick();
        n_total++; if (readDataM !== e.data) $display("FAIL rd_hold got %h want %h", readDataM, e.data); else n_pass++;
    endtask

    task automatic test_held_start();
        int dc, bc, d0; logic [31:0] rd; logic er; exp_t e;
        sb.push_back('{32'hCAFEF00D, 1'b0});
        run_txn(1'b0, 32'h10, 32'h0, 1, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (rd !== e.data) $display("FAIL held_rd got %h want %h", rd, e.data); else n_pass++;
        d0 = done_cnt;
        AXIStart = 1'b1;
        repeat (30) tick();
        n_total++; if (done_cnt !== d0) $display("FAIL held_retrigger got %0d want %0d", done_cnt, d0); else n_pass++;
        AXIStart = 1'b0;
        tick();
        sb.push_back('{32'hCAFEF00D, 1'b0});
        run_txn(1'b0, 32'h10, 32'h0, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (dc !== L + 2) $display("FAIL held_second got %0d want %0d", dc, L + 2); else n_pass++;
    endtask

    task automatic test_busy_drop();
        int dc, bc, d0; logic [31:0] rd; logic er; exp_t e;
        d0 = done_cnt;
        sb.push_back('{32'h0, 1'b0});
        run_txn(1'b1, 32'h20, 32'h0BADCAFE, 0, 1, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (bc !== L + 3) $display("FAIL busy_len got %0d want %0d", bc, L + 3); else n_pass++;
        repeat (10) tick();
        n_total++; if (done_cnt !== d0 + 1) $display("FAIL busy_single_done got %0d want %0d", done_cnt - d0, 1); else n_pass++;
        sb.push_back('{32'h0BADCAFE, 1'b0});
        run_txn(1'b0, 32'h20, 32'h0, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (rd !== e.data) $display("FAIL busy_rd got %h want %h", rd, e.data); else n_pass++;
    endtask

    task automatic test_wrap();
        int dc, bc; logic [31:0] rd; logic er; exp_t e;
        run_txn(1'b1, 32'h4, 32'h0, 0, 0, dc, bc, rd, er);
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
        sb.push_back('{32'h0, 1'b1});
`else
        sb.push_back('{32'h0, 1'b0});
`endif
        run_txn(1'b1, 32'h1004, 32'h12345678, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (dc !== L + 2) $display("FAIL wrap_wr_cycle got %0d want %0d", dc, L + 2); else n_pass++;
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
        n_total++; if (er !== e.err) $display("FAIL oor_wr_err got %b want %b", er, e.err); else n_pass++;
        sb.push_back('{32'h0, 1'b0});
`else
        sb.push_back('{32'h12345678, 1'b0});
`endif
        run_txn(1'b0, 32'h4, 32'h0, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (rd !== e.data) $display("FAIL wrap_rd got %h want %h", rd, e.data); else n_pass++;
`ifdef AXI_MEM_RESPONDER_OOR_ERR_EN
        n_total++; if (er !== e.err) $display("FAIL inrange_err got %b want %b", er, e.err); else n_pass++;
        sb.push_back('{32'hDEADBEEF, 1'b1});
        run_txn(1'b0, 32'h1004, 32'h0, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (rd !== e.data) $display("FAIL oor_rd got %h want %h", rd, e.data); else n_pass++;
        n_total++; if (er !== e.err) $display("FAIL oor_rd_err got %b want %b", er, e.err); else n_pass++;
        tick();
        n_total++; if (errM !== 1'b0) $display("FAIL err_outside_done got %b want 0", errM); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int dc, bc, d0; logic [31:0] rd; logic er; exp_t e;
        run_txn(1'b1, 32'h8, 32'hA5A50008, 0, 0, dc, bc, rd, er);
        AXIStart = 1'b1; DRW = 1'b1; addressM = 32'h8; writeDataM = 32'hFFFFFFFF;
        tick();
        AXIStart = 1'b0;
        tick();
        reset = 1'b0;
        d0 = done_cnt;
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        n_total++; if (done_cnt !== d0) $display("FAIL mid_reset_done got %0d want %0d", done_cnt, d0); else n_pass++;
        n_total++; if (readDataM !== 32'h0) $display("FAIL mid_reset_rdata got %h want 0", readDataM); else n_pass++;
        sb.push_back('{32'hA5A50008, 1'b0});
        run_txn(1'b0, 32'h8, 32'h0, 0, 0, dc, bc, rd, er);
        e = sb.pop_front();
        n_total++; if (rd !== e.data) $display("FAIL mid_reset_rd got %h want %h", rd, e.data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held_start();
        test_busy_drop();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
